dual_deq_stage: RTL and testbench
=================================

# dual_deq_stage

Two-wide consumer for the 2-way superscalar queue: drives the queue's dual dequeue port and re-presents the entries, oldest first, on two registered output lanes to the decode/rename stage. A 2-entry skid buffer absorbs partial downstream acceptance (0, 1 or 2 per cycle), compacts surviving entries toward lane 0 and refills from the queue head in the same cycle. Sits between the instruction queue's dequeue side and rename.

## Interface
- WIDTH, 32, entry width; must equal the queue's WIDTH.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush; empties the buffer.
- q_empty  in  1  queue holds 0 entries.
- q_almost_empty  in  1  queue holds exactly 1 entry.
- q_deq_data  in  WIDTH  queue head entry.
- q_deq_data_1  in  WIDTH  entry at queue head+1.
- q_deq  out  1  pop one entry (queue head).
- q_deq_1  out  1  pop a second entry; only ever asserted with q_deq.
- out_valid  out  1  lane 0 (oldest) holds an entry.
- out_data  out  WIDTH  lane 0 entry.
- out_valid_1  out  1  lane 1 holds an entry; never 1 while out_valid is 0.
- out_data_1  out  WIDTH  lane 1 entry.
- out_accept  in  2  entries consumed this cycle, in order from lane 0.
- occupancy  out  2  buffered entries, 0..2.

## Operation
- State cnt in {EMPTY=0, ONE=1, TWO=2}; slots slot0 (oldest) and slot1.
- out_valid = (cnt >= 1); out_valid_1 = (cnt == 2); out_data = slot0; out_data_1 = slot1; occupancy = cnt.
- acc = min(out_accept, cnt); out_accept = 3 is treated as 2. Over-acceptance is clamped, never underflows.
- keep = cnt - acc; free = 2 - keep.
- avail = 0 if q_empty, 1 if q_almost_empty, else 2.
- fill = min(free, avail); q_deq = (fill >= 1); q_deq_1 = (fill == 2).
- Next slots: a kept entry moves to slot0 (slot1 -> slot0 when cnt=2 and acc=1). New entries append in order: q_deq_data to first free slot, q_deq_data_1 to the next.
- Next cnt = keep + fill.
- Unaccepted entries hold: data and valid stay stable until accepted or flushed.
- flush: cnt <= 0; q_deq = q_deq_1 = 0 in the flush cycle. flush overrides out_accept and fill.
- Slots whose valid is 0 keep stale data and may be left unchanged.

## Timing
- Reset (rst_n low, async): cnt = 0, slot0 = slot1 = 0, so out_valid = out_valid_1 = 0, out_data = out_data_1 = 0, occupancy = 0. q_deq = q_deq_1 = 0 while in reset.
- Reset asserted mid-operation discards buffered entries. Entries the queue popped in that edge are lost; the queue is reset with the same pipeline.
- Latency: an entry popped by q_deq in cycle N appears on out_valid/out_data in cycle N+1.
- Throughput: 2 entries/cycle sustained when out_accept = 2 and the queue holds at least 2 entries.
- q_deq and q_deq_1 are combinational from out_accept, cnt, q_empty, q_almost_empty and flush. This is a same-cycle accept-to-pop path. There is no combinational path from q_deq_data* to any output.
- Simultaneous accept and refill in one cycle is required. No bubble when downstream drains and the queue is non-empty.

## Structure
- The shared pipeline package holds the 2-bit count typedef used for out_accept, occupancy and cnt, plus the EMPTY/ONE/TWO state constants.
- A min2 helper function on 2-bit counts is placed in the package, since rename uses it too.
- Single module; no sub-module. Compaction and append are one always_comb mux per slot.

## Test plan
- Reset, then queue has 5 entries (A..E) and out_accept = 2 every cycle -> cycle 1: q_deq = q_deq_1 = 1. Cycle 2: lanes A,B. Cycle 3: C,D. Cycle 4: E only (q_almost_empty path, q_deq_1 = 0).
- cnt = 2 (A,B) with queue head C,D and out_accept = 1 -> q_deq = 1, q_deq_1 = 0. Next cycle: out_data = B, out_data_1 = C.
- cnt = 2 with out_accept = 0 for 4 cycles -> q_deq = 0 throughout; A,B stable.
- cnt = 1 with out_accept = 3 -> treated as 1. Next cnt = fill only, no underflow.
- flush with cnt = 2, out_accept = 2 and queue non-empty -> q_deq = 0. Next cycle: out_valid = 0, occupancy = 0.
- rst_n pulsed low between clock edges while cnt = 2 -> outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dual_deq_stage_pkg.sv
// Shared pipeline types: 2-bit entry count, its named values and a min helper.
package dual_deq_stage_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t EMPTY = 2'd0;
    localparam cnt_t ONE   = 2'd1;
    localparam cnt_t TWO   = 2'd2;

    function automatic cnt_t min2(input cnt_t a, input cnt_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/dual_deq_stage.sv
// Two-wide dequeue consumer: 2-entry skid buffer between the instruction queue
// and rename, compacting survivors toward lane 0 and refilling in the same cycle.
module dual_deq_stage
    import dual_deq_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             q_empty,
    input  logic             q_almost_empty,
    input  logic [WIDTH-1:0] q_deq_data,
    input  logic [WIDTH-1:0] q_deq_data_1,
    output logic             q_deq,
    output logic             q_deq_1,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid_1,
    output logic [WIDTH-1:0] out_data_1,
    input  logic [1:0]       out_accept,
    output logic [1:0]       occupancy
);

    // Handshake: an entry on a lane is offered while its valid is high and is
    // held unchanged until consumed; out_accept counts consumed entries in lane
    // order and is clamped to what is offered. q_deq/q_deq_1 pop the queue head
    // in the same cycle, so popped data must be present on q_deq_data*.
    cnt_t             cnt, cnt_n;
    logic [WIDTH-1:0] slot0, slot1, slot0_n, slot1_n;
    cnt_t             acc, keep, free, avail, fill, accept_c;

    always_comb begin
        accept_c = (out_accept == 2'd3) ? TWO : cnt_t'(out_accept);
        acc      = min2(accept_c, cnt);
        keep     = cnt - acc;
        free     = TWO - keep;
        avail    = q_empty ? EMPTY : (q_almost_empty ? ONE : TWO);
        fill     = (flush || !rst_n) ? EMPTY : min2(free, avail);

        slot0_n = slot0;
        slot1_n = slot1;
        if (!flush) begin
            case (keep)
                EMPTY: begin
                    if (fill != EMPTY) slot0_n = q_deq_data;
                    if (fill == TWO)   slot1_n = q_deq_data_1;
                end
                ONE: begin
                    // A single survivor always lands in slot0; the new entry follows it.
                    if (cnt == TWO)    slot0_n = slot1;
                    if (fill != EMPTY) slot1_n = q_deq_data;
                end
                default: ;
            endcase
        end
        cnt_n = flush ? EMPTY : (keep + fill);
    end

    assign q_deq   = (fill != EMPTY);
    assign q_deq_1 = (fill == TWO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= EMPTY;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            cnt   <= cnt_n;
            slot0 <= slot0_n;
            slot1 <= slot1_n;
        end
    end

    assign out_valid   = (cnt != EMPTY);
    assign out_valid_1 = (cnt == TWO);
    assign out_data    = slot0;
    assign out_data_1  = slot1;
    assign occupancy   = cnt;

endmodule

// File: tb/tb_dual_deq_stage.sv
// Directed bench for dual_deq_stage with a small behavioural queue feeding it.
module tb_dual_deq_stage;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             q_empty;
    logic             q_almost_empty;
    logic [WIDTH-1:0] q_deq_data;
    logic [WIDTH-1:0] q_deq_data_1;
    logic             q_deq;
    logic             q_deq_1;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid_1;
    logic [WIDTH-1:0] out_data_1;
    logic [1:0]       out_accept;
    logic [1:0]       occupancy;

    logic [WIDTH-1:0] qm[$];
    int checks;
    int passed;

    dual_deq_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .q_empty(q_empty), .q_almost_empty(q_almost_empty),
        .q_deq_data(q_deq_data), .q_deq_data_1(q_deq_data_1),
        .q_deq(q_deq), .q_deq_1(q_deq_1),
        .out_valid(out_valid), .out_data(out_data),
        .out_valid_1(out_valid_1), .out_data_1(out_data_1),
        .out_accept(out_accept), .occupancy(occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic refresh();
        q_empty        = (qm.size() == 0);
        q_almost_empty = (qm.size() == 1);
        q_deq_data     = (qm.size() > 0) ? qm[0] : '0;
        q_deq_data_1   = (qm.size() > 1) ? qm[1] : '0;
        #1;
    endtask

    // Advance one clock, popping the queue as the DUT requested before the edge.
    task automatic step();
        logic dq, dq1;
        dq  = q_deq;
        dq1 = q_deq_1;
        @(posedge clk);
        if (dq && qm.size() > 0)  void'(qm.pop_front());
        if (dq1 && qm.size() > 0) void'(qm.pop_front());
        #1;
        refresh();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_accept = 2'd2;
        qm = '{32'h1111_1111, 32'h2222_2222};
        @(posedge clk); #1;
        refresh();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passed++;
        checks++; if (out_valid_1 !== 1'b0) $display("FAIL reset_out_valid_1 got %b exp 0", out_valid_1); else passed++;
        checks++; if (out_data !== '0 || out_data_1 !== '0) $display("FAIL reset_data got %h %h exp 0 0", out_data, out_data_1); else passed++;
        checks++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy got %0d exp 0", occupancy); else passed++;
        checks++; if (q_deq !== 1'b0 || q_deq_1 !== 1'b0) $display("FAIL reset_q_deq got %b%b exp 00", q_deq, q_deq_1); else passed++;
        qm.delete();
        refresh();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_stream();
        qm = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
        out_accept = 2'd2;
        refresh();
        checks++; if ({q_deq, q_deq_1} !== 2'b11) $display("FAIL stream_c1_deq got %b%b exp 11", q_deq, q_deq_1); else passed++;
        step();
        checks++; if ({out_valid, out_valid_1, out_data, out_data_1} !== {2'b11, 32'hA, 32'hB})
            $display("FAIL stream_c2_lanes got %b%b %h %h exp 11 a b", out_valid, out_valid_1, out_data, out_data_1); else passed++;
        checks++; if ({q_deq, q_deq_1} !== 2'b11) $display("FAIL stream_c2_deq got %b%b exp 11", q_deq, q_deq_1); else passed++;
        step();
        checks++; if ({out_valid, out_valid_1, out_data, out_data_1} !== {2'b11, 32'hC, 32'hD})
            $display("FAIL stream_c3_lanes got %b%b %h %h exp 11 c d", out_valid, out_valid_1, out_data, out_data_1); else passed++;
        checks++; if ({q_deq, q_deq_1} !== 2'b10) $display("FAIL stream_c3_almost_empty got %b%b exp 10", q_deq, q_deq_1); else passed++;
        step();
        checks++; if ({out_valid, out_valid_1, out_data, occupancy} !== {2'b10, 32'hE, 2'd1})
            $display("FAIL stream_c4_lane got %b%b %h occ %0d exp 10 e 1", out_valid, out_valid_1, out_data, occupancy); else passed++;
        checks++; if ({q_deq, q_deq_1} !== 2'b00) $display("FAIL stream_c4_empty got %b%b exp 00", q_deq, q_deq_1); else passed++;
        step();
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) $display("FAIL stream_drained got occ %0d v %b exp 0 0", occupancy, out_valid); else passed++;
    endtask

    task automatic test_partial();
        qm = '{32'hA, 32'hB, 32'hC, 32'hD};
        out_accept = 2'd0;
        refresh();
        step();
        out_accept = 2'd1;
        refresh();
        checks++; if ({q_deq, q_deq_1} !== 2'b10) $display("FAIL partial_deq got %b%b exp 10", q_deq, q_deq_1); else passed++;
        step();
        checks++; if ({occupancy, out_data, out_data_1} !== {2'd2, 32'hB, 32'hC})
            $display("FAIL partial_compact got occ %0d %h %h exp 2 b c", occupancy, out_data, out_data_1); else passed++;
    endtask

    task automatic test_stall();
        out_accept = 2'd0;
        refresh();
        for (int i = 0; i < 4; i++) begin
            checks++; if ({q_deq, q_deq_1} !== 2'b00) $display("FAIL stall_deq_%0d got %b%b exp 00", i, q_deq, q_deq_1); else passed++;
            step();
            checks++; if ({out_valid, out_valid_1, out_data, out_data_1} !== {2'b11, 32'hB, 32'hC})
                $display("FAIL stall_hold_%0d got %b%b %h %h exp 11 b c", i, out_valid, out_valid_1, out_data, out_data_1); else passed++;
        end
    endtask

    task automatic test_over_accept();
        qm.delete();
        out_accept = 2'd1;
        refresh();
        step();
        checks++; if ({occupancy, out_data} !== {2'd1, 32'hC}) $display("FAIL over_setup got occ %0d %h exp 1 c", occupancy, out_data); else passed++;
        qm = '{32'hF};
        out_accept = 2'd3;
        refresh();
        checks++; if ({q_deq, q_deq_1} !== 2'b10) $display("FAIL over_deq got %b%b exp 10", q_deq, q_deq_1); else passed++;
        step();
        checks++; if ({occupancy, out_valid_1, out_data} !== {2'd1, 1'b0, 32'hF})
            $display("FAIL over_clamp got occ %0d v1 %b %h exp 1 0 f", occupancy, out_valid_1, out_data); else passed++;
    endtask

    task automatic test_flush();
        qm = '{32'h10, 32'h11, 32'h12, 32'h13};
        out_accept = 2'd0;
        refresh();
        step();
        checks++; if ({occupancy, out_data, out_data_1} !== {2'd2, 32'hF, 32'h10})
            $display("FAIL flush_setup got occ %0d %h %h exp 2 f 10", occupancy, out_data, out_data_1); else passed++;
        flush = 1'b1;
        out_accept = 2'd2;
        refresh();
        checks++; if ({q_deq, q_deq_1} !== 2'b00) $display("FAIL flush_deq got %b%b exp 00", q_deq, q_deq_1); else passed++;
        step();
        flush = 1'b0;
        checks++; if ({out_valid, out_valid_1, occupancy} !== {2'b00, 2'd0})
            $display("FAIL flush_empty got %b%b occ %0d exp 00 0", out_valid, out_valid_1, occupancy); else passed++;
        out_accept = 2'd0;
        refresh();
        step();
        checks++; if ({occupancy, out_data, out_data_1} !== {2'd2, 32'h11, 32'h12})
            $display("FAIL flush_refill got occ %0d %h %h exp 2 11 12", occupancy, out_data, out_data_1); else passed++;
    endtask

    task automatic test_async_reset();
        qm.delete();
        refresh();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, out_valid_1, occupancy} !== {2'b00, 2'd0})
            $display("FAIL async_valid got %b%b occ %0d exp 00 0", out_valid, out_valid_1, occupancy); else passed++;
        checks++; if (out_data !== '0 || out_data_1 !== '0) $display("FAIL async_data got %h %h exp 0 0", out_data, out_data_1); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_stream();
        test_partial();
        test_stall();
        test_over_accept();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
